// File: rtl/brute_force_matcher_load_scheduler.sv
// Load scheduler for the brute-force descriptor matcher.
// Accepts host load requests for the primary (query) buffer or one of two
// secondary (candidate) ping-pong slots, starts the dispatch unit, tracks
// buffer credit and kicks off match passes on the engine.
// Optional feature: define BFM_LOAD_SCHED_TIMEOUT_EN to enable the watchdog
// that abandons a load whose completion never arrives.
module brute_force_matcher_load_scheduler #(
    parameter int unsigned C_MAX_KP         = 4096,
    parameter int unsigned C_TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [15:0] ld_req_count,
    input  logic        ld_req_is_prim,
    output logic        begin_load_fifo,
    output logic [1:0]  descriptor_buffer_select,
    output logic [15:0] total_keypoint_load_count,
    input  logic        dispatch_unit_done_buffer_load,
    output logic        sec_buffer_not_loading,
    output logic        sec_wr_slot,
    output logic        sec_rd_slot,
    output logic        engine_start,
    input  logic        engine_done,
    input  logic        prim_release,
    output logic        err_count,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_ISSUE     = 3'b010,
        ST_WAIT_DONE = 3'b100
    } state_t;

    state_t     state;
    logic       prim_loaded;
    logic [1:0] sec_count;
    logic       engine_busy;

    logic target_has_room;
    logic accept;
    logic count_zero;
    logic count_over;
    logic load_done;
    logic prim_done;
    logic sec_done;
    logic eng_done_ok;
    logic eng_go;
    logic wd_expire;

    // The watchdog counter is 17 bits wide; a limit outside that range cannot be honoured.
    if (C_TIMEOUT_CYCLES > 32'h0001_ffff) begin : g_timeout_out_of_range
    end

    assign target_has_room = ld_req_is_prim ? !prim_loaded : (sec_count < 2'd2);
    assign ld_req_ready    = !rst && (state == ST_IDLE) && target_has_room;
    assign accept          = ld_req_valid && ld_req_ready;
    assign count_zero      = (ld_req_count == 16'd0);
    assign count_over      = (32'(ld_req_count) > C_MAX_KP);

    assign load_done   = (state == ST_WAIT_DONE) && dispatch_unit_done_buffer_load;
    assign prim_done   = load_done && descriptor_buffer_select[0];
    assign sec_done    = load_done && descriptor_buffer_select[1];
    assign eng_done_ok = engine_done && engine_busy;
    assign eng_go      = prim_loaded && (sec_count != 2'd0) && !engine_busy;

    // Select is only non-zero while a load is in flight, so it alone tells us
    // whether the secondary buffer is being written.
    assign sec_buffer_not_loading = !descriptor_buffer_select[1];

`ifdef BFM_LOAD_SCHED_TIMEOUT_EN
    logic [16:0] wd_cnt;

    assign wd_expire = (state == ST_WAIT_DONE) && !dispatch_unit_done_buffer_load &&
                       (wd_cnt == 17'(C_TIMEOUT_CYCLES - 1));

    // Watchdog: count cycles spent waiting for done; flag and abandon on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= 17'd0;
            err_timeout <= 1'b0;
        end else begin
            if (state != ST_WAIT_DONE) begin
                wd_cnt <= 17'd0;
            end else if (!dispatch_unit_done_buffer_load) begin
                wd_cnt <= wd_cnt + 17'd1;
            end
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Load FSM: accept a request, pulse the dispatch unit, hold target until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= ST_IDLE;
            begin_load_fifo           <= 1'b0;
            descriptor_buffer_select  <= 2'b00;
            total_keypoint_load_count <= 16'd0;
            err_count                 <= 1'b0;
        end else begin
            begin_load_fifo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (count_over) begin
                            err_count <= 1'b1;
                        end else if (!count_zero) begin
                            total_keypoint_load_count <= ld_req_count;
                            descriptor_buffer_select  <= ld_req_is_prim ? 2'b01 : 2'b10;
                            begin_load_fifo           <= 1'b1;
                            state                     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (load_done || wd_expire) begin
                        descriptor_buffer_select <= 2'b00;
                        state                    <= ST_IDLE;
                    end
                end
                default: begin
                    descriptor_buffer_select <= 2'b00;
                    state                    <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer credit and engine handshake: loads add credit, match passes consume it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prim_loaded  <= 1'b0;
            sec_count    <= 2'd0;
            engine_busy  <= 1'b0;
            engine_start <= 1'b0;
            sec_wr_slot  <= 1'b0;
            sec_rd_slot  <= 1'b0;
        end else begin
            engine_start <= eng_go;

            if (eng_go) begin
                engine_busy <= 1'b1;
            end else if (eng_done_ok) begin
                engine_busy <= 1'b0;
            end

            if (prim_done) begin
                prim_loaded <= 1'b1;
            end else if (prim_release && !engine_busy) begin
                prim_loaded <= 1'b0;
            end

            if (sec_done) begin
                sec_wr_slot <= !sec_wr_slot;
            end
            if (eng_done_ok) begin
                sec_rd_slot <= !sec_rd_slot;
            end

            case ({sec_done, eng_done_ok})
                2'b10:   sec_count <= sec_count + 2'd1;
                2'b01:   sec_count <= sec_count - 2'd1;
                default: sec_count <= sec_count;
            endcase
        end
    end

endmodule

// File: doc/brute_force_matcher_load_scheduler.md
BRUTE_FORCE_MATCHER_LOAD_SCHEDULER -- requirements
Module: brute_force_matcher_load_scheduler

Interface
REQ-001 Parameter C_MAX_KP, default 4096; maximum keypoints accepted per load request.
REQ-002 Parameter C_TIMEOUT_CYCLES, default 65535; watchdog limit in clk cycles.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld_req_valid  input  1  host load request valid.
REQ-006 ld_req_ready  output  1  scheduler accepts the request this cycle.
REQ-007 ld_req_count  input  16  keypoints to load.
REQ-008 ld_req_is_prim  input  1  1 = primary (query) buffer, 0 = secondary (candidate) buffer.
REQ-009 begin_load_fifo  output  1  single-cycle pulse that starts the dispatch unit.
REQ-010 descriptor_buffer_select  output  2  target buffer: bit0 primary, bit1 secondary; one-hot while a load is in flight, else 0.
REQ-011 total_keypoint_load_count  output  16  count for the dispatch unit.
REQ-012 dispatch_unit_done_buffer_load  input  1  dispatch unit completion pulse.
REQ-013 sec_buffer_not_loading  output  1  high unless a secondary load is in flight.
REQ-014 sec_wr_slot / sec_rd_slot  output  1 each  secondary ping-pong slot being loaded / consumed.
REQ-015 engine_start  output  1  pulse starting a match pass; engine_done  input  1  pass finished and the secondary slot is released.
REQ-016 prim_release  input  1  host invalidates the primary buffer.
REQ-017 err_count / err_timeout  output  1 each  sticky error flags.

Function
REQ-018 FSM states are ST_IDLE, ST_ISSUE and ST_WAIT_DONE, one-hot encoded.
REQ-019 In ST_IDLE, ld_req_ready=1 iff (is_prim and prim_loaded=0) or (!is_prim and sec_count<2); it is combinational on ld_req_is_prim.
REQ-020 Accept (valid and ready) with count in 1..C_MAX_KP: latch count and target, then go to ST_ISSUE.
REQ-021 Accept with count=0: drop it; no begin pulse, no state change.
REQ-022 Accept with count>C_MAX_KP: drop it and set err_count.
REQ-023 ST_ISSUE: begin_load_fifo=1 for exactly one cycle (the cycle after accept), then go to ST_WAIT_DONE.
REQ-024 descriptor_buffer_select and total_keypoint_load_count stay stable from ST_ISSUE until the done cycle inclusive.
REQ-025 ST_WAIT_DONE plus done: if primary, set prim_loaded; if secondary, sec_count+1 and toggle sec_wr_slot; go to ST_IDLE.
REQ-026 ld_req_ready is asserted no earlier than the cycle after done.
REQ-027 sec_buffer_not_loading=0 only in ST_ISSUE/ST_WAIT_DONE with a secondary target.
REQ-028 engine_start is a registered pulse, asserted the cycle after prim_loaded=1, sec_count>0 and engine_busy=0 all hold; engine_start sets engine_busy.
REQ-029 engine_done: clear engine_busy, sec_count-1, toggle sec_rd_slot.
REQ-030 engine_done while engine_busy=0 is ignored.
REQ-031 Secondary done and engine_done in the same cycle: sec_count unchanged, both slot pointers toggle.
REQ-032 prim_release clears prim_loaded only when engine_busy=0; it is ignored otherwise.
REQ-033 done received outside ST_WAIT_DONE is ignored.

Reset
REQ-034 Reset state: ST_IDLE; prim_loaded, sec_count, engine_busy, both slot pointers and both error flags = 0.
REQ-035 Output reset values: begin_load_fifo=0, descriptor_buffer_select=0, total_keypoint_load_count=0, engine_start=0, ld_req_ready=0, sec_buffer_not_loading=1.
REQ-036 Reset mid-load aborts the load and discards all buffer credit.

Configuration
REQ-037 With macro BFM_LOAD_SCHED_TIMEOUT_EN defined: a 17-bit counter runs in ST_WAIT_DONE; on reaching C_TIMEOUT_CYCLES without done, set err_timeout, go to ST_IDLE and grant no credit.
REQ-038 Without BFM_LOAD_SCHED_TIMEOUT_EN: no counter exists, err_timeout is tied to 0, and the scheduler waits indefinitely.

Verification
REQ-039 Primary request, count=100, accepted at cycle N -> begin pulse at N+1, select=01 and count=100 held; done -> prim_loaded=1, a new primary request is refused.
REQ-040 Three secondary loads of 50 each -> third ld_req_ready=0 until engine_done; sec_wr_slot sequence 0,1,0.
REQ-041 Primary plus one secondary loaded -> engine_start one cycle later; engine_done in the same cycle as a secondary done -> sec_count stays 1.
REQ-042 count=0 -> no begin pulse; count=5000 -> err_count=1 and no begin pulse.
REQ-043 Macro defined, C_TIMEOUT_CYCLES=20, done withheld -> err_timeout at 20 cycles, state ST_IDLE, sec_count unchanged.
REQ-044 rst asserted during ST_WAIT_DONE -> all outputs at reset values the next cycle; a late done is ignored.
